countdown_mod_timer: RTL and testbench
======================================

// Module: countdown_mod_timer
// PURPOSE
//   Mod-N down-counter timer: the decrementing counterpart of the mod-7 up-counter with enable.
//   Loads a start value, counts down one step per prescaled tick while enabled, and signals
//   wrap (borrow) and completion (done). Drives timeouts and cascaded down-count chains in lab datapaths.
// PARAMETERS
//   WIDTH     3  counter width; must satisfy 2**WIDTH >= MODULUS (elaboration assertion)
//   MODULUS   7  count range 0..MODULUS-1; MODULUS >= 2
//   PRESCALE  2  clock cycles per count tick; PRESCALE >= 1 (1 = tick every enabled cycle)
// PORTS
//   clock        in   1      system clock, all state on posedge
//   reset        in   1      synchronous, active-high global reset
//   enable       in   1      count enable; 0 freezes value and prescaler phase
//   start        in   1      1-cycle pulse: load load_value and enter RUN
//   stop         in   1      1-cycle pulse: abort to IDLE, value held
//   repeat_mode  in   1      1 = wrap 0 -> MODULUS-1 and keep running; 0 = one-shot
//   load_value   in   WIDTH  start value, sampled on start
//   value        out  WIDTH  current count (registered)
//   borrow       out  1      1-cycle pulse, registered, on every 0-step tick
//   done         out  1      1-cycle pulse, high while in DONE
//   busy         out  1      1 while in RUN
// BEHAVIOUR
//   - Reset (any state, dominates all inputs): state=IDLE, value=0, borrow=0, done=0, busy=0, prescaler=0.
//   - States IDLE, RUN, DONE. busy = (state==RUN); done = (state==DONE).
//   - IDLE: value holds. start -> RUN next cycle, value <= load_value, prescaler cleared.
//   - Load clamp: load_value >= MODULUS loads MODULUS-1.
//   - Prescaler: counts 0..PRESCALE-1 only in RUN with enable=1; tick = enable & (presc==PRESCALE-1);
//     wraps to 0 on tick; cleared on start, stop, leaving RUN.
//   - RUN, tick, value>0: value <= value-1.
//   - RUN, tick, value==0: borrow <= 1 for one cycle; repeat_mode=1: value <= MODULUS-1, stay RUN;
//     repeat_mode=0: value stays 0, state -> DONE.
//   - DONE: lasts exactly one cycle, then IDLE; start in DONE -> RUN (reload), accepted.
//   - Latency: start edge t0 -> value=load at t0+1; first decrement at edge t0+PRESCALE
//     (enable held 1); each later step every PRESCALE enabled cycles.
//   - enable=0 in RUN: value, prescaler, state frozen; no borrow; start/stop still honoured.
//   - Priority: reset > stop > start > tick. stop in IDLE/DONE -> IDLE. start in RUN restarts
//     (reload, prescaler clear, no borrow that cycle).
//   - repeat_mode sampled at each 0-step tick (may change mid-run).
//   - Arithmetic unsigned, WIDTH bits; value never exceeds MODULUS-1.
// STRUCTURE
//   - Shared package counter_pkg: typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t.
//   - Sub-module tick_prescaler (clock, reset, enable, clear -> tick), parameter PRESCALE;
//     PRESCALE=1 degenerates to tick = enable.
//   - Top: one always_ff for state/value/borrow, one always_comb for next state.
// TESTING (MODULUS=7, WIDTH=3, PRESCALE=2 unless noted)
//   1 reset high 2 cycles mid-RUN at value=4 -> next cycle value=0, busy=0, done=0, borrow=0.
//   2 load_value=3, repeat_mode=0, start, enable=1 -> value 3,3,2,2,1,1,0,0; then borrow=1 and done=1
//     same cycle, busy=0; IDLE next cycle, value stays 0.
//   3 load_value=1, repeat_mode=1 -> 1,1,0,0,6,6,5..; borrow pulse exactly on the 0->6 step; busy stays 1.
//   4 load_value=7 -> value loads 6; load_value=5 -> loads 5.
//   5 RUN at value=4, prescaler mid-phase, enable=0 for 5 cycles -> value 4 throughout; step resumes
//     1 enabled cycle after enable returns.
//   6 RUN, stop and start same cycle -> IDLE, value held, busy=0; start in DONE -> RUN with new load.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the countdown timer and related counter blocks.
package counter_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles into one tick every PRESCALE cycles; PRESCALE=1 gives tick = enable.
module tick_prescaler #(
  parameter int unsigned PRESCALE = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] presc_q, presc_d;

  assign tick = enable & (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (clear || tick) begin
      presc_d = '0;
    end else if (enable) begin
      presc_d = presc_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/countdown_mod_timer.sv
// Mod-N down-counting timer with load clamp, prescaled ticks, borrow pulse and one-shot done.
module countdown_mod_timer
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH    = 3,
  parameter int unsigned MODULUS  = 7,
  parameter int unsigned PRESCALE = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             repeat_mode,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             borrow,
  output logic             done,
  output logic             busy
);

  if ((64'd1 << WIDTH) < 64'(MODULUS) || MODULUS < 2 || PRESCALE < 1) begin : g_bad_params
    $error("countdown_mod_timer: need 2**WIDTH >= MODULUS >= 2 and PRESCALE >= 1");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             borrow_q, borrow_d;
  logic             tick, presc_clear;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clock (clock),
    .reset (reset),
    .enable(enable & (state_q == RUN)),
    .clear (presc_clear),
    .tick  (tick)
  );

  // Priority: stop > start > tick.
  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    borrow_d = 1'b0;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = RUN;
      value_d = (load_value > MAX_VAL) ? MAX_VAL : load_value;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            if (value_q != '0) begin
              value_d = value_q - 1'b1;
            end else begin
              borrow_d = 1'b1;
              if (repeat_mode) begin
                value_d = MAX_VAL;
              end else begin
                state_d = DONE;
              end
            end
          end
        end
        DONE:    state_d = IDLE;
        default: ;
      endcase
    end
    presc_clear = start | stop | (state_d != RUN);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      value_q  <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      borrow_q <= borrow_d;
    end
  end

  assign value  = value_q;
  assign borrow = borrow_q;
  assign done   = (state_q == DONE);
  assign busy   = (state_q == RUN);

endmodule

// File: tb/tb_countdown_mod_timer.sv
// Table-driven bench for countdown_mod_timer (MODULUS=7, WIDTH=3, PRESCALE=2).
module tb_countdown_mod_timer;

  typedef struct {
    logic       rst;
    logic       en;
    logic       st;
    logic       sp;
    logic       rp;
    logic [2:0] ld;
    logic [2:0] e_value;
    logic       e_borrow;
    logic       e_done;
    logic       e_busy;
  } vec_t;

  typedef struct {
    int         idx;
    logic [2:0] e_value;
    logic       e_borrow;
    logic       e_done;
    logic       e_busy;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       repeat_mode = 1'b0;
  logic [2:0] load_value = 3'd0;
  logic [2:0] value;
  logic       borrow, done, busy;

  int checks = 0;
  int failures = 0;
  vec_t vecs[$];
  exp_t exp_q[$];

  countdown_mod_timer #(
    .WIDTH   (3),
    .MODULUS (7),
    .PRESCALE(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .start      (start),
    .stop       (stop),
    .repeat_mode(repeat_mode),
    .load_value (load_value),
    .value      (value),
    .borrow     (borrow),
    .done       (done),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  function automatic void add(input logic rst, input logic en, input logic st, input logic sp,
                              input logic rp, input logic [2:0] ld, input logic [2:0] ev,
                              input logic eb, input logic ed, input logic ebusy);
    vec_t v;
    v.rst = rst; v.en = en; v.st = st; v.sp = sp; v.rp = rp; v.ld = ld;
    v.e_value = ev; v.e_borrow = eb; v.e_done = ed; v.e_busy = ebusy;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, req);
    end
  endtask

  initial begin
    exp_t e;
    int   n;

    // reset / load 3 one-shot: 3,3,2,2,1,1,0,0 then borrow+done
    add(1,0,0,0,0,0, 0,0,0,0);
    add(1,0,0,0,0,0, 0,0,0,0);
    add(0,1,1,0,0,3, 3,0,0,1);
    add(0,1,0,0,0,0, 3,0,0,1);
    add(0,1,0,0,0,0, 2,0,0,1);
    add(0,1,0,0,0,0, 2,0,0,1);
    add(0,1,0,0,0,0, 1,0,0,1);
    add(0,1,0,0,0,0, 1,0,0,1);
    add(0,1,0,0,0,0, 0,0,0,1);
    add(0,1,0,0,0,0, 0,0,0,1);
    add(0,1,0,0,0,0, 0,1,1,0);
    add(0,1,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0);
    // repeat mode: 1,1,0,0,6(borrow),6,5,5
    add(0,1,1,0,1,1, 1,0,0,1);
    add(0,1,0,0,1,0, 1,0,0,1);
    add(0,1,0,0,1,0, 0,0,0,1);
    add(0,1,0,0,1,0, 0,0,0,1);
    add(0,1,0,0,1,0, 6,1,0,1);
    add(0,1,0,0,1,0, 6,0,0,1);
    add(0,1,0,0,1,0, 5,0,0,1);
    add(0,1,0,0,1,0, 5,0,0,1);
    // clamp 7 -> 6, restart with 5, then reach 4 with prescaler mid-phase
    add(0,1,1,0,0,7, 6,0,0,1);
    add(0,1,0,0,0,0, 6,0,0,1);
    add(0,1,1,0,0,5, 5,0,0,1);
    add(0,1,0,0,0,0, 5,0,0,1);
    add(0,1,0,0,0,0, 4,0,0,1);
    add(0,1,0,0,0,0, 4,0,0,1);
    for (int i = 0; i < 5; i++) add(0,0,0,0,0,0, 4,0,0,1);
    add(0,1,0,0,0,0, 3,0,0,1);
    add(0,1,0,0,0,0, 3,0,0,1);
    // stop + start together: stop wins, value held in IDLE
    add(0,1,1,1,0,2, 3,0,0,0);
    add(0,1,0,0,0,0, 3,0,0,0);
    // load 0, finish, then start while in DONE
    add(0,1,1,0,0,0, 0,0,0,1);
    add(0,1,0,0,0,0, 0,0,0,1);
    add(0,1,0,0,0,0, 0,1,1,0);
    add(0,1,1,0,0,2, 2,0,0,1);
    add(0,1,0,0,0,0, 2,0,0,1);
    add(0,1,0,0,0,0, 1,0,0,1);
    // reset mid-run at 4
    add(0,1,1,0,0,4, 4,0,0,1);
    add(1,1,0,0,0,0, 0,0,0,0);
    add(1,1,0,0,0,0, 0,0,0,0);
    add(0,1,0,0,0,0, 0,0,0,0);
    // plain stop in RUN
    add(0,1,1,0,0,6, 6,0,0,1);
    add(0,1,0,0,0,0, 6,0,0,1);
    add(0,1,0,1,0,0, 6,0,0,0);
    add(0,1,0,0,0,0, 6,0,0,0);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; enable = vecs[i].en; start = vecs[i].st;
      stop = vecs[i].sp; repeat_mode = vecs[i].rp; load_value = vecs[i].ld;
      e.idx = i; e.e_value = vecs[i].e_value; e.e_borrow = vecs[i].e_borrow;
      e.e_done = vecs[i].e_done; e.e_busy = vecs[i].e_busy;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      e = exp_q.pop_front();
      check("value", e.idx, int'(value), int'(e.e_value));
      check("borrow", e.idx, int'(borrow), int'(e.e_borrow));
      check("done", e.idx, int'(done), int'(e.e_done));
      check("busy", e.idx, int'(busy), int'(e.e_busy));
    end

    // One-shot from 2: done must arrive 6 edges after the load edge.
    reset = 0; stop = 0; repeat_mode = 0; enable = 1; start = 1; load_value = 3'd2;
    @(posedge clock);
    #1;
    start = 0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("done_latency", -1, n, 6);
    check("done_borrow", -1, int'(borrow), 1);
    check("done_value", -1, int'(value), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
